// File: rtl/beta_mul_seq.sv
// Sequential 32x32 shift-and-add multiplier (low 32 bits of the product) for the Beta ALU MUL op.
// cla_add32 is the block's only adder; one radix-2 iteration per clock.

module cla_add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co,
    output logic        g,
    output logic        p
);
    logic [31:0] gi, pi, c;
    logic [7:0]  gg, gp;
    logic [8:0]  gc;

    assign gi = a & b;
    assign pi = a ^ b;
    assign gc[0] = ci;

    // 4-bit lookahead groups, second-level carry chained across groups
    for (genvar k = 0; k < 8; k++) begin : g_grp
        localparam int B = 4 * k;
        assign c[B]   = gc[k];
        assign c[B+1] = gi[B] | (pi[B] & gc[k]);
        assign c[B+2] = gi[B+1] | (pi[B+1] & gi[B]) | (pi[B+1] & pi[B] & gc[k]);
        assign c[B+3] = gi[B+2] | (pi[B+2] & gi[B+1]) | (pi[B+2] & pi[B+1] & gi[B])
                      | (pi[B+2] & pi[B+1] & pi[B] & gc[k]);
        assign gg[k]  = gi[B+3] | (pi[B+3] & gi[B+2]) | (pi[B+3] & pi[B+2] & gi[B+1])
                      | (pi[B+3] & pi[B+2] & pi[B+1] & gi[B]);
        assign gp[k]  = &pi[B+3:B];
        assign gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end

    assign s  = pi ^ c;
    assign co = gc[8];
    assign g  = gc[8] & ~(&gp & ci);
    assign p  = &gp;
endmodule

// state | meaning
// IDLE  | waiting for start, no valid result
// RUN   | one shift-and-add iteration per clock
// DONE  | y holds a*b, waiting for next start
module beta_mul_seq #(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] y
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [31:0] acc, acc_nxt, mcand, mcand_nxt, mplier, mplier_nxt;
    logic [4:0]  count, count_nxt;
    logic [31:0] sum, mplier_shr;
    logic        unused_co, unused_g, unused_p;

    cla_add32 u_add (
        .a  (acc),
        .b  (mcand & {32{mplier[0]}}),
        .ci (1'b0),
        .s  (sum),
        .co (unused_co),
        .g  (unused_g),
        .p  (unused_p)
    );

    assign mplier_shr = {1'b0, mplier[31:1]};

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        count_nxt  = count;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    acc_nxt    = '0;
                    mcand_nxt  = a;
                    mplier_nxt = b;
                    count_nxt  = '0;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                acc_nxt    = sum;
                mcand_nxt  = {mcand[30:0], 1'b0};
                mplier_nxt = mplier_shr;
                count_nxt  = count + 5'd1;
                if (count == 5'd31 || (EARLY_EXIT && mplier_shr == '0))
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            count  <= count_nxt;
        end
    end

    // outputs decode registered state only; acc is the product once in DONE
    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign y    = acc;
endmodule

// File: tb/tb_beta_mul_seq.sv
// Self-checking bench for beta_mul_seq: both EARLY_EXIT settings run side by side,
// checked against constant vectors and a plain-arithmetic reference model.

module tb_beta_mul_seq;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        busy0, done0, busy1, done1;
    logic [31:0] y0, y1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    beta_mul_seq #(.EARLY_EXIT(1'b0)) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .y(y0));

    beta_mul_seq #(.EARLY_EXIT(1'b1)) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .y(y1));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        int          lat0;
        int          lat1;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_lat(input bit ee, input logic [31:0] mb);
        int m = 0;
        if (!ee) return 32;
        for (int i = 0; i < 32; i++)
            if (mb[i]) m = i;
        return m + 1;
    endfunction

    // Launch the same operands on both instances, then count edges until each reports done.
    task automatic run_pair(input logic [31:0] ta, input logic [31:0] tb,
                            output logic [31:0] r0, output logic [31:0] r1,
                            output int l0, output int l1);
        @(negedge clock);
        a0 = ta; b0 = tb; a1 = ta; b1 = tb;
        start0 = 1'b1; start1 = 1'b1;
        @(negedge clock);
        start0 = 1'b0; start1 = 1'b0;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        check("busy0_at_accept", {63'b0, busy0}, 64'd1);
        check("done1_at_accept", {63'b0, done1}, 64'd0);
        l0 = -1; l1 = -1; r0 = '0; r1 = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (busy0 && done0) check("busy0_and_done0", 64'd1, 64'd0);
            if (busy1 && done1) check("busy1_and_done1", 64'd1, 64'd0);
            if (l0 < 0 && done0) begin l0 = n; r0 = y0; end
            if (l1 < 0 && done1) begin l1 = n; r1 = y1; end
            if (l0 >= 0 && l1 >= 0) break;
        end
    endtask

    initial begin
        logic [31:0] r0, r1, ra, rb, expy;
        int l0, l1, lat;

        vecs[0] = '{32'd3,        32'd5,        32'd15,        32, 3};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  32, 32};
        vecs[2] = '{32'h00010000, 32'h00010000, 32'h00000000,  32, 17};
        vecs[3] = '{32'h80000000, 32'h00000003, 32'h80000000,  32, 2};
        vecs[4] = '{32'h12345678, 32'h00000006, 32'h6D3A06D0,  32, 3};
        vecs[5] = '{32'h12345678, 32'h00000000, 32'h00000000,  32, 1};
        vecs[6] = '{32'h00000005, 32'h80000000, 32'h80000000,  32, 32};
        vecs[7] = '{32'd7,        32'd9,        32'd63,        32, 4};

        // reset, with start pending to confirm reset wins
        start0 = 1'b1; start1 = 1'b1; a0 = 32'd9; b0 = 32'd9;
        repeat (2) @(negedge clock);
        start0 = 1'b0; start1 = 1'b0;
        check("rst_busy0", {63'b0, busy0}, 64'd0);
        check("rst_done0", {63'b0, done0}, 64'd0);
        check("rst_y0", {32'b0, y0}, 64'd0);
        check("rst_busy1", {63'b0, busy1}, 64'd0);
        check("rst_done1", {63'b0, done1}, 64'd0);
        check("rst_y1", {32'b0, y1}, 64'd0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            run_pair(vecs[i].a, vecs[i].b, r0, r1, l0, l1);
            check($sformatf("vec%0d_y0", i), {32'b0, r0}, {32'b0, vecs[i].y});
            check($sformatf("vec%0d_y1", i), {32'b0, r1}, {32'b0, vecs[i].y});
            check($sformatf("vec%0d_lat0", i), 64'(l0), 64'(vecs[i].lat0));
            check($sformatf("vec%0d_lat1", i), 64'(l1), 64'(vecs[i].lat1));
        end

        // result holds in DONE while idle
        run_pair(32'd3, 32'd5, r0, r1, l0, l1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("hold_y0", {32'b0, y0}, 64'd15);
            check("hold_done0", {63'b0, done0}, 64'd1);
        end

        // start and operand changes during RUN are ignored
        @(negedge clock);
        a0 = 32'd7; b0 = 32'd9; start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (n == 5) begin a0 = 32'd1; b0 = 32'd1; start0 = 1'b1; end
            if (n == 6) start0 = 1'b0;
            if (done0) begin lat = n; break; end
        end
        check("hs_y", {32'b0, y0}, 64'd63);
        check("hs_lat", 64'(lat), 64'd32);

        // start held high across DONE: one done cycle, then a new run
        a0 = 32'd2; b0 = 32'd2; start0 = 1'b1;
        @(negedge clock);
        check("b2b_done_drop", {63'b0, done0}, 64'd0);
        check("b2b_busy", {63'b0, busy0}, 64'd1);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (done0) begin lat = n; break; end
        end
        start0 = 1'b0;
        check("b2b_y", {32'b0, y0}, 64'd4);
        check("b2b_lat", 64'(lat), 64'd32);

        // reset in the middle of a run
        @(negedge clock);
        a0 = 32'd5; b0 = 32'd5; a1 = 32'd5; b1 = 32'd5;
        start0 = 1'b1; start1 = 1'b1;
        @(negedge clock);
        start0 = 1'b0; start1 = 1'b0;
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("midrst_busy0", {63'b0, busy0}, 64'd0);
        check("midrst_done0", {63'b0, done0}, 64'd0);
        check("midrst_y0", {32'b0, y0}, 64'd0);
        check("midrst_y1", {32'b0, y1}, 64'd0);
        run_pair(32'd4, 32'd4, r0, r1, l0, l1);
        check("post_rst_y0", {32'b0, r0}, 64'd16);
        check("post_rst_lat0", 64'(l0), 64'd32);
        check("post_rst_y1", {32'b0, r1}, 64'd16);
        check("post_rst_lat1", 64'(l1), 64'd3);

        // random regression against the arithmetic model
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'd1;
                2: rb = 32'hFFFFFFFF;
                3: ra = 32'd1 << $urandom_range(0, 31);
                4: rb = 32'd1 << $urandom_range(0, 31);
                5: ra = 32'd0;
                default: ;
            endcase
            expy = ra * rb;
            run_pair(ra, rb, r0, r1, l0, l1);
            check("rnd_y0", {32'b0, r0}, {32'b0, expy});
            check("rnd_y1", {32'b0, r1}, {32'b0, expy});
            check("rnd_lat0", 64'(l0), 64'(model_lat(1'b0, rb)));
            check("rnd_lat1", 64'(l1), 64'(model_lat(1'b1, rb)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
